// File: rtl/seq_generator.sv
// ============================================================================
// seq_generator : serial pattern transmitter, MSB first, R repeats, G-cycle gaps
// Revision 1.0
// ============================================================================
`default_nettype none

module seq_generator #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int c_IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [c_IDX_W-1:0] c_MSB = c_IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t               r_state, w_state_nx;
  logic [PAT_W-1:0]     r_pat,   w_pat_nx;
  logic [c_IDX_W-1:0]   r_idx,   w_idx_nx;
  logic [CNT_W-1:0]     r_rep,   w_rep_nx;
  logic [GAP_W-1:0]     r_glen,  w_glen_nx;
  logic [GAP_W-1:0]     r_gcnt,  w_gcnt_nx;
  logic                 r_x,     w_x_nx;
  logic                 r_xv,    w_xv_nx;
  logic                 r_busy,  w_busy_nx;
  logic                 r_done,  w_done_nx;

  logic [CNT_W-1:0]     w_rep_init;
  logic [c_IDX_W-1:0]   w_idx_dec;

  // r_rep holds repetitions still owed after the one in flight, so R=0 and R=1 both load 0
  assign w_rep_init = (repeat_cnt == '0) ? '0 : repeat_cnt - CNT_W'(1);
  assign w_idx_dec  = r_idx - c_IDX_W'(1);

  always_comb begin
    w_state_nx = r_state;
    w_pat_nx   = r_pat;
    w_idx_nx   = r_idx;
    w_rep_nx   = r_rep;
    w_glen_nx  = r_glen;
    w_gcnt_nx  = r_gcnt;
    w_x_nx     = 1'b0;
    w_xv_nx    = 1'b0;
    w_busy_nx  = 1'b0;
    w_done_nx  = 1'b0;

    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_state_nx = SHIFT;
          w_pat_nx   = pattern;
          w_rep_nx   = w_rep_init;
          w_glen_nx  = gap;
          w_idx_nx   = c_MSB;
          w_gcnt_nx  = '0;
          w_x_nx     = pattern[PAT_W-1];
          w_xv_nx    = 1'b1;
          w_busy_nx  = 1'b1;
        end
      end

      SHIFT: begin
        if (abort) begin
          w_state_nx = IDLE;
          w_idx_nx   = '0;
          w_rep_nx   = '0;
          w_gcnt_nx  = '0;
        end else if (r_idx != '0) begin
          w_idx_nx  = w_idx_dec;
          w_x_nx    = r_pat[w_idx_dec];
          w_xv_nx   = 1'b1;
          w_busy_nx = 1'b1;
        end else if (r_rep != '0) begin
          w_rep_nx  = r_rep - CNT_W'(1);
          w_busy_nx = 1'b1;
          if (r_glen != '0) begin
            w_state_nx = GAP;
            w_gcnt_nx  = r_glen - GAP_W'(1);
          end else begin
            w_idx_nx = c_MSB;
            w_x_nx   = r_pat[PAT_W-1];
            w_xv_nx  = 1'b1;
          end
        end else begin
          w_state_nx = IDLE;
          w_done_nx  = 1'b1;
        end
      end

      GAP: begin
        if (abort) begin
          w_state_nx = IDLE;
          w_idx_nx   = '0;
          w_rep_nx   = '0;
          w_gcnt_nx  = '0;
        end else if (r_gcnt == '0) begin
          w_state_nx = SHIFT;
          w_idx_nx   = c_MSB;
          w_x_nx     = r_pat[PAT_W-1];
          w_xv_nx    = 1'b1;
          w_busy_nx  = 1'b1;
        end else begin
          w_gcnt_nx = r_gcnt - GAP_W'(1);
          w_busy_nx = 1'b1;
        end
      end

      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_pat   <= '0;
      r_idx   <= '0;
      r_rep   <= '0;
      r_glen  <= '0;
      r_gcnt  <= '0;
      r_x     <= 1'b0;
      r_xv    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pat   <= w_pat_nx;
      r_idx   <= w_idx_nx;
      r_rep   <= w_rep_nx;
      r_glen  <= w_glen_nx;
      r_gcnt  <= w_gcnt_nx;
      r_x     <= w_x_nx;
      r_xv    <= w_xv_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
    end
  end

  assign x       = r_x;
  assign x_valid = r_xv;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_seq_generator.sv
// ============================================================================
// tb_seq_generator : directed self-checking bench for seq_generator
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_seq_generator;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic [3:0] pattern;
  logic [7:0] repeat_cnt;
  logic [3:0] gap;
  logic       x;
  logic       x_valid;
  logic       busy;
  logic       done;

  int checks;
  int errors;

  logic [63:0] xs, vs, bs, ds;

  seq_generator #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .gap        (gap),
    .x          (x),
    .x_valid    (x_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Samples n cycles at falling edges; the first sample is the cycle after the launch edge.
  task automatic collect(input int n, input bit hold_start,
                         output logic [63:0] o_x, output logic [63:0] o_v,
                         output logic [63:0] o_b, output logic [63:0] o_d);
    o_x = '0; o_v = '0; o_b = '0; o_d = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 0 && !hold_start) begin
        start      = 1'b0;
        pattern    = ~pattern;
        repeat_cnt = 8'd7;
        gap        = 4'd9;
      end
      o_x = {o_x[62:0], x};
      o_v = {o_v[62:0], x_valid};
      o_b = {o_b[62:0], busy};
      o_d = {o_d[62:0], done};
    end
  endtask

  task automatic launch(input logic [3:0] p, input logic [7:0] r, input logic [3:0] g);
    pattern    = p;
    repeat_cnt = r;
    gap        = g;
    start      = 1'b1;
  endtask

  initial begin
    int n_busy, n_valid, n_done, n_ones;
    checks = 0; errors = 0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = '0; repeat_cnt = '0; gap = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {60'd0, x, x_valid, busy, done}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1111 once
    launch(4'b1111, 8'd1, 4'd0);
    collect(6, 1'b0, xs, vs, bs, ds);
    check("t1_x",    xs, 64'b111100);
    check("t1_v",    vs, 64'b111100);
    check("t1_busy", bs, 64'b111100);
    check("t1_done", ds, 64'b000010);

    // 1011 x3 with 2-cycle gaps
    launch(4'b1011, 8'd3, 4'd2);
    collect(18, 1'b0, xs, vs, bs, ds);
    check("t2_x",    xs, 64'b101100101100101100);
    check("t2_v",    vs, 64'b111100111100111100);
    check("t2_busy", bs, 64'b111111111111111100);
    check("t2_done", ds, 64'b000000000000000010);

    // repeat 0 behaves as 1
    launch(4'b1001, 8'd0, 4'd5);
    collect(6, 1'b0, xs, vs, bs, ds);
    check("t3_x",    xs, 64'b100100);
    check("t3_v",    vs, 64'b111100);
    check("t3_busy", bs, 64'b111100);
    check("t3_done", ds, 64'b000010);

    // back-to-back repeats with start held high throughout
    launch(4'b1101, 8'd2, 4'd0);
    collect(10, 1'b1, xs, vs, bs, ds);
    check("t4_x",    xs, 64'b1101110101);
    check("t4_v",    vs, 64'b1111111101);
    check("t4_busy", bs, 64'b1111111101);
    check("t4_done", ds, 64'b0000000010);
    start = 1'b0;
    abort = 1'b1;
    collect(1, 1'b1, xs, vs, bs, ds);
    abort = 1'b0;
    check("t4_abort", {xs[0], vs[0], bs[0], ds[0]}, 64'd0);

    // abort on the third bit
    launch(4'b1011, 8'd2, 4'd1);
    collect(3, 1'b0, xs, vs, bs, ds);
    check("t5_x",    xs, 64'b101);
    check("t5_busy", bs, 64'b111);
    abort = 1'b1;
    collect(1, 1'b1, xs, vs, bs, ds);
    abort = 1'b0;
    check("t5_after", {xs[0], vs[0], bs[0], ds[0]}, 64'd0);
    collect(4, 1'b1, xs, vs, bs, ds);
    check("t5_quiet", xs | vs | bs | ds, 64'd0);

    launch(4'b0110, 8'd1, 4'd0);
    collect(6, 1'b0, xs, vs, bs, ds);
    check("t5_rerun_x", xs, 64'b011000);
    check("t5_rerun_d", ds, 64'b000010);

    // abort and start together in idle
    launch(4'b1111, 8'd1, 4'd0);
    abort = 1'b1;
    collect(2, 1'b0, xs, vs, bs, ds);
    abort = 1'b0;
    check("abort_start_idle", xs | vs | bs | ds, 64'd0);

    // reset during gap
    launch(4'b1100, 8'd2, 4'd3);
    collect(5, 1'b0, xs, vs, bs, ds);
    check("t6_x",    xs, 64'b11000);
    check("t6_v",    vs, 64'b11110);
    check("t6_busy", bs, 64'b11111);
    #2 reset_n = 1'b0;
    #1 check("t6_async_reset", {60'd0, x, x_valid, busy, done}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    collect(4, 1'b1, xs, vs, bs, ds);
    check("t6_idle", xs | vs | bs | ds, 64'd0);

    // maximum repeat and gap: 255*4 + 254*15 = 4830 busy cycles
    launch(4'b1010, 8'd255, 4'd15);
    n_busy = 0; n_valid = 0; n_done = 0; n_ones = 0;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 0) start = 1'b0;
      n_busy  += int'(busy);
      n_valid += int'(x_valid);
      n_done  += int'(done);
      n_ones  += int'(x);
    end
    check("max_busy",  64'(n_busy),  64'd4830);
    check("max_valid", 64'(n_valid), 64'd1020);
    check("max_ones",  64'(n_ones),  64'd510);
    check("max_done",  64'(n_done),  64'd1);
    check("max_idle",  {63'd0, busy}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
